// File: rtl/mul_reconstruct.sv
// Sequential shift-add multiply-accumulate: PRO = QIN*DIN + RIN, the inverse of the restoring divider.
// Optional MUL_ZERO_SKIP_EN: a zero operand bypasses the CALC iterations.
module mul_reconstruct #(
    parameter int unsigned N  = 5,
    parameter int unsigned CW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   QIN,
    input  logic [N-1:0]   DIN,
    input  logic [N-1:0]   RIN,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] PRO
);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StAddr,
        StDone
    } state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic [CW-1:0]   r_cnt;
    logic [N:0]      r_a;
    logic [N-1:0]    r_q;
    logic [N-1:0]    r_d;
    logic [N-1:0]    r_r;
    logic [2*N-1:0]  r_pro;
    logic [N:0]      w_sum;
    logic            w_zero;
    logic            w_last;

`ifdef MUL_ZERO_SKIP_EN
    assign w_zero = (QIN == '0) || (DIN == '0);
`else
    assign w_zero = 1'b0;
`endif

    assign w_last = (r_cnt == CW'(N - 1));
    // A < 2^N before each add, so the N+1-bit sum cannot overflow
    assign w_sum  = r_q[0] ? (r_a + {1'b0, r_d}) : r_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_d = w_zero ? StAddr : StCalc;
                end
            end
            StCalc: begin
                if (w_last) begin
                    w_state_d = StAddr;
                end
            end
            StAddr:  w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_q   <= '0;
            r_d   <= '0;
            r_r   <= '0;
            r_pro <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_d   <= DIN;
                        r_r   <= RIN;
                        r_a   <= '0;
                        r_cnt <= '0;
                        r_q   <= w_zero ? '0 : QIN;
                    end
                end
                StCalc: begin
                    // {A,Q} <= {sum,Q} >> 1 with a zero shifted into the A MSB
                    r_a   <= {1'b0, w_sum[N:1]};
                    r_q   <= {w_sum[0], r_q[N-1:1]};
                    r_cnt <= r_cnt + CW'(1);
                end
                StAddr: begin
                    r_pro <= {r_a[N-1:0], r_q} + {{N{1'b0}}, r_r};
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (r_state != StIdle);
    assign done = (r_state == StDone);
    assign PRO  = r_pro;

endmodule

// File: tb/tb_mul_reconstruct.sv
// Directed, table-driven and divider-inverse checks for mul_reconstruct.
module tb_mul_reconstruct;

    localparam int N = 5;
`ifdef MUL_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [N-1:0]   QIN = '0;
    logic [N-1:0]   DIN = '0;
    logic [N-1:0]   RIN = '0;
    logic           busy;
    logic           done;
    logic [2*N-1:0] PRO;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    mul_reconstruct #(.N(N), .CW(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .QIN   (QIN),
        .DIN   (DIN),
        .RIN   (RIN),
        .busy  (busy),
        .done  (done),
        .PRO   (PRO)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0]   q;
        logic [N-1:0]   d;
        logic [N-1:0]   r;
        logic [2*N-1:0] pro;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [N-1:0] q, input logic [N-1:0] d);
        return (ZS && (q == 0 || d == 0)) ? 2 : N + 2;
    endfunction

    // lat counts edges from the start edge (which is edge 1) until done is seen
    task automatic run_op(input logic [N-1:0] q, input logic [N-1:0] d, input logic [N-1:0] r,
                          output int lat, output int bcnt, output logic [2*N-1:0] pro);
        @(negedge clk);
        QIN = q; DIN = d; RIN = r; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        bcnt = busy ? 1 : 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
        pro = PRO;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];
    int lat, bcnt, dcnt, t1, t2, k;
    logic [2*N-1:0] pro;
    logic [N-1:0] rq, rd, rr;

    initial begin
        vecs.push_back('{5'd13, 5'd7,  5'd5,  10'd96});
        vecs.push_back('{5'd31, 5'd31, 5'd30, 10'd991});
        vecs.push_back('{5'd0,  5'd19, 5'd4,  10'd4});
        vecs.push_back('{5'd3,  5'd5,  5'd1,  10'd16});
        vecs.push_back('{5'd25, 5'd17, 5'd16, 10'd441});
        vecs.push_back('{5'd7,  5'd30, 5'd29, 10'd239});
        vecs.push_back('{5'd31, 5'd1,  5'd0,  10'd31});
        vecs.push_back('{5'd12, 5'd0,  5'd9,  10'd9});
        vecs.push_back('{5'd1,  5'd1,  5'd0,  10'd1});

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_pro", int'(PRO), 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].q, vecs[i].d, vecs[i].r, lat, bcnt, pro);
            check($sformatf("pro[%0d]", i), int'(pro), int'(vecs[i].pro));
            check($sformatf("lat[%0d]", i), lat, exp_lat(vecs[i].q, vecs[i].d));
            check($sformatf("busy_cycles[%0d]", i), bcnt, exp_lat(vecs[i].q, vecs[i].d));
            check($sformatf("done_pulse[%0d]", i), int'(done), 0);
            check($sformatf("idle_after[%0d]", i), int'(busy), 0);
        end

        // result holds while idle
        repeat (5) @(posedge clk);
        #1;
        check("pro_hold", int'(PRO), 1);

        // reset in the third CALC cycle abandons the op
        @(negedge clk);
        QIN = 5'd9; DIN = 5'd9; RIN = 5'd0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_pro", int'(PRO), 0);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        check("midrst_no_done", dcnt, 0);
        run_op(5'd3, 5'd5, 5'd1, lat, bcnt, pro);
        check("after_rst_pro", int'(pro), 16);

        // start while busy is ignored
        @(negedge clk);
        QIN = 5'd6; DIN = 5'd6; RIN = 5'd0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        QIN = 5'd2; DIN = 5'd2; RIN = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        check("busy_start_done_count", dcnt, 1);
        check("busy_start_pro", int'(PRO), 36);

        // start held high: back-to-back ops N+3 cycles apart
        @(negedge clk);
        QIN = 5'd10; DIN = 5'd3; RIN = 5'd2; start = 1'b1;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (done !== 1'b1 && k < 40);
        t1 = cyc;
        check("b2b_first_seen", int'(done), 1);
        check("b2b_first_pro", int'(PRO), 32);
        @(negedge clk);
        QIN = 5'd1; DIN = 5'd1; RIN = 5'd0;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (done !== 1'b1 && k < 40);
        t2 = cyc;
        start = 1'b0;
        check("b2b_second_seen", int'(done), 1);
        check("b2b_second_pro", int'(PRO), 1);
        check("b2b_gap", t2 - t1, N + 3);
        repeat (12) @(posedge clk);

        // divider outputs (q,d,r) with r<d rebuild the dividend
        for (int i = 0; i < 40; i++) begin
            rd = 5'($urandom_range(1, 31));
            rq = 5'($urandom_range(0, 31));
            rr = 5'($urandom_range(0, int'(rd) - 1));
            run_op(rq, rd, rr, lat, bcnt, pro);
            check($sformatf("inv q=%0d d=%0d r=%0d", rq, rd, rr), int'(pro),
                  int'(rq) * int'(rd) + int'(rr));
            check($sformatf("inv_lat[%0d]", i), lat, exp_lat(rq, rd));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
